// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 keyboard receiver with scan-code FIFO and a 32-bit bus read port
//   clk, rst_n      system clock, asynchronous active-low reset
//   ps2_clk/data    raw PS/2 pins (asynchronous, synchronised internally)
//   sel, re, addr   bus select, one-cycle read strobe, byte offset (addr[2] decoded)
//   dout            read data: offset 0 = {nonempty, head code}, offset 4 = {overflow, count}
//   irq             high while the FIFO holds at least one code
// Build option: define KBD_PARITY_CHECK_EN to require odd parity over data + parity bit.
module kbd_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        sel,
  input  logic        re,
  input  logic [2:0]  addr,
  output logic [31:0] dout,
  output logic        irq
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [6:0] DEPTH = 7'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);
  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3;

  // clk_sync_q: [0] first stage, [1] synced value, [2] synced value one cycle earlier
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic [1:0] state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic push_q, push_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic fall, bit_in, par_ok, ne, full, pop, push_ok, drop, stat_rd;
  logic [7:0] head;
  logic unused;

  assign unused = ^addr[1:0];
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

`ifdef KBD_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else if (fall && state_q == S_PARITY) par_q <= bit_in;
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Receiver: the timeout counter restarts on every falling edge and only runs mid-frame.
  // The shift register is not cleared on a start bit so it still holds the accepted code
  // on the cycle the FIFO write happens.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    tmo_d   = (state_q == S_IDLE || fall) ? '0 : tmo_q + TW'(1);
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          state_d = bit_in ? S_IDLE : S_DATA;
          bcnt_d  = 3'd0;
        end
        S_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          state_d = (bcnt_q == 3'd7) ? S_PARITY : S_DATA;
        end
        S_PARITY: state_d = S_STOP;
        default: begin
          state_d = S_IDLE;
          push_d  = bit_in & par_ok;
        end
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end
  end

  // FIFO: a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign ne       = count_q != 7'd0;
  assign full     = count_q == DEPTH;
  assign pop      = sel & re & ~addr[2] & ne;
  assign stat_rd  = sel & re & addr[2];
  assign push_ok  = push_q & (~full | pop);
  assign drop     = push_q & full & ~pop;
  assign wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d  = count_q + 7'(push_ok) - 7'(pop);
  assign ovf_d    = drop | (ovf_q & ~stat_rd);
  assign head     = ne ? mem_q[rd_ptr_q] : 8'h00;
  assign dout     = !sel ? 32'h0 : addr[2] ? {ovf_q, 24'h0, count_q} : {23'h0, ne, head};
  assign irq      = ne;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      state_q    <= S_IDLE;
      bcnt_q     <= 3'd0;
      shift_q    <= 8'h00;
      tmo_q      <= '0;
      push_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 7'd0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end

  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
endmodule

// File: tb/tb_kbd_ctrl.sv
// tb_kbd_ctrl: table-driven and scoreboard checks for kbd_ctrl
module tb_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int H     = 8;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk, rst_n, ps2_clk, ps2_data, sel, re, irq;
  logic [2:0] addr;
  logic [31:0] dout;
  int nerr = 0;
  int nchk = 0;
  logic [7:0] exp_q[$];
  logic exp_ovf = 1'b0;

  typedef struct {
    logic [7:0]  code;
    logic        par;
    logic        stop;
    logic        acc;
    logic [31:0] dout0;
  } vec_t;
  vec_t tbl[8];

  kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .sel(sel), .re(re), .addr(addr), .dout(dout), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] c, input bit good, input logic s);
    vec_t v;
    v.code  = c;
    v.par   = good ? ~^c : ^c;
    v.stop  = s;
    v.acc   = s & (PCHK ? good : 1'b1);
    v.dout0 = v.acc ? {23'h0, 1'b1, c} : 32'h0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_rd(input logic a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = {a, 2'b00};
    #1 d = dout;
    @(posedge clk);
    #1 sel = 1'b0; re = 1'b0; addr = 3'd0;
  endtask

  task automatic peek(input logic a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; re = 1'b0; addr = {a, 2'b00};
    #1 d = dout;
    sel = 1'b0; addr = 3'd0;
  endtask

  task automatic sb_push(input logic [7:0] c);
    if (exp_q.size() < DEPTH) exp_q.push_back(c);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] d;
    bus_rd(1'b0, d);
    if (exp_q.size() == 0) check(name, d, 32'h0);
    else begin
      check(name, d, {23'h0, 1'b1, exp_q[0]});
      void'(exp_q.pop_front());
    end
  endtask

  task automatic stat_chk(input string name);
    logic [31:0] d;
    bus_rd(1'b1, d);
    check(name, d, {exp_ovf, 24'h0, 7'(exp_q.size())});
    exp_ovf = 1'b0;
  endtask

  // pop=1 issues a head read timed to hit the same clock edge as the FIFO write
  task automatic send_bit(input logic b, input bit pop);
    logic [31:0] d;
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop) begin
      repeat (2) @(negedge clk);
      pop_chk("simul_pop_head");
      peek(1'b1, d);
      check("simul_count", d, {25'h0, 7'(DEPTH)});
    end
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic p, input logic s, input bit pop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i], 1'b0);
    send_bit(p, 1'b0);
    send_bit(s, pop);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    nerr++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    logic [31:0] d;
    tbl[0] = mk(8'h1C, 1'b1, 1'b1);
    tbl[1] = mk(8'h1C, 1'b0, 1'b1);
    tbl[2] = mk(8'h5A, 1'b1, 1'b0);
    tbl[3] = mk(8'hF0, 1'b1, 1'b1);
    tbl[4] = mk(8'h00, 1'b1, 1'b1);
    tbl[5] = mk(8'hFF, 1'b1, 1'b1);
    tbl[6] = mk(8'h81, 1'b0, 1'b1);
    tbl[7] = mk(8'h3C, 1'b1, 1'b0);
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; sel = 1'b0; re = 1'b0; addr = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_irq", irq, 1'b0);
    peek(1'b1, d);
    check("rst_status", d, 32'h0);
    peek(1'b0, d);
    check("rst_head", d, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].code, tbl[i].par, tbl[i].stop, 1'b0);
      if (tbl[i].acc) sb_push(tbl[i].code);
      peek(1'b0, d);
      check($sformatf("vec%0d_head", i), d, tbl[i].dout0);
      check($sformatf("vec%0d_irq", i), irq, tbl[i].acc);
      @(negedge clk);
      sel = 1'b0; re = 1'b1; addr = 3'd0;
      #1 check($sformatf("vec%0d_sel0", i), dout, 32'h0);
      @(posedge clk);
      #1 re = 1'b0;
      stat_chk($sformatf("vec%0d_status", i));
      pop_chk($sformatf("vec%0d_pop", i));
    end

    for (int c = 1; c <= 9; c++) begin
      send_frame(8'(c), ~^(8'(c)), 1'b1, 1'b0);
      sb_push(8'(c));
    end
    stat_chk("ovf_status");
    for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("ovf_pop%0d", i));
    stat_chk("ovf_cleared");
    pop_chk("pop_empty");
    stat_chk("pop_empty_status");

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    repeat (TMO + 2) @(negedge clk);
    check("tmo_irq", irq, 1'b0);
    send_frame(8'hF0, ~^(8'hF0), 1'b1, 1'b0);
    sb_push(8'hF0);
    stat_chk("tmo_status");
    pop_chk("tmo_pop");

    for (int c = 8'h10; c < 8'h18; c++) begin
      send_frame(8'(c), ~^(8'(c)), 1'b1, 1'b0);
      sb_push(8'(c));
    end
    send_frame(8'h5A, ~^(8'h5A), 1'b1, 1'b1);
    sb_push(8'h5A);
    stat_chk("simul_status");
    for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("simul_drain%0d", i));

    for (int c = 8'h20; c < 8'h29; c++) begin
      send_frame(8'(c), ~^(8'(c)), 1'b1, 1'b0);
      sb_push(8'(c));
    end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    check("midrst_irq", irq, 1'b0);
    peek(1'b1, d);
    check("midrst_status", d, 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h29, ~^(8'h29), 1'b1, 1'b0);
    sb_push(8'h29);
    stat_chk("midrst_after_status");
    pop_chk("midrst_after_pop");
    stat_chk("midrst_empty");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/kbd_ctrl.md
KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, idle clk cycles mid-frame before the receiver aborts the frame.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from pin, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from pin, asynchronous.
REQ-007 SHALL have port sel  input  1  bus select; driven by the decoder's keyboard-region select (addr[23:20]==4'h5).
REQ-008 SHALL have port re  input  1  bus read strobe, one cycle per access.
REQ-009 SHALL have port addr  input  3  byte offset in region; only addr[2] decoded.
REQ-010 SHALL have port dout  output  32  read data; feeds the decoder's keyboard read-data input.
REQ-011 SHALL have port irq  output  1  high while FIFO non-empty.

Function
REQ-012 SHALL synchronise ps2_clk and ps2_data through two flops each before use.
REQ-013 SHALL detect a PS/2 falling edge as synced ps2_clk 1 in the previous cycle and 0 in the current cycle; sample ps2_data only on that cycle.
REQ-014 SHALL run receiver FSM IDLE -> DATA -> PARITY -> STOP -> IDLE: IDLE leaves on an edge with data 0 (start bit), and a start bit of 1 keeps IDLE; DATA shifts 8 bits LSB-first; PARITY samples 1 bit; STOP samples 1 bit.
REQ-015 SHALL, on the STOP edge, accept the frame iff stop bit==1 and the parity rule (REQ-026/027) holds; otherwise discard silently.
REQ-016 SHALL push an accepted code into the FIFO on the clock edge following the STOP-sampling cycle; count visible on dout one cycle later.
REQ-017 SHALL count clk cycles since the last falling edge while not IDLE; at TIMEOUT_CYC, return to IDLE and discard the partial frame.
REQ-018 SHALL drop an accepted code when the FIFO is full and set sticky overflow.
REQ-019 SHALL drive dout combinationally; addr[2]==0 gives {23'b0, nonempty, head[7:0]}, with head=0 when empty; addr[2]==1 gives {overflow, 24'b0, count[6:0]}.
REQ-020 SHALL drive dout=0 when sel==0.
REQ-021 SHALL pop the head on the clock edge where sel & re & addr[2]==0 & nonempty; a pop when empty has no effect.
REQ-022 SHALL clear overflow on the clock edge where sel & re & addr[2]==1, unless a drop occurs on the same edge, in which case overflow stays set.
REQ-023 SHALL, on simultaneous push and pop: if non-empty, do both with count unchanged, also when full; if empty, push only.
REQ-024 SHALL wrap read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-025 SHALL on rst_n low asynchronously force: FSM IDLE, shift register 0, timeout counter 0, FIFO pointers and count 0, overflow 0, synchroniser flops 1, irq 0, and dout=0 or status-only per REQ-019; reset mid-frame discards the frame.

Configuration
REQ-026 SHALL, with KBD_PARITY_CHECK_EN defined, require the 8 data bits plus parity bit to have odd parity for acceptance.
REQ-027 SHALL, without KBD_PARITY_CHECK_EN, ignore the parity bit; acceptance then depends only on start==0 and stop==1.

Verification
REQ-028 SHALL cover: send frame code 8'h1C with odd parity 0 and stop 1 -> dout at offset 0 == 32'h0000011C, irq=1, offset 4 count=1.
REQ-029 SHALL cover: KBD_PARITY_CHECK_EN defined, send 8'h1C with parity 1 -> FIFO stays empty, irq=0; with the macro undefined, the same frame gives count=1.
REQ-030 SHALL cover: send 9 valid codes 8'h01..8'h09 with default depth and no reads -> count=8, offset 4 bit31=1, popped codes 8'h01..8'h08; status read then shows bit31=0.
REQ-031 SHALL cover: send a start bit plus 4 data bits, then idle TIMEOUT_CYC+2 cycles, then a full frame 8'hF0 -> only 8'hF0 in FIFO.
REQ-032 SHALL cover: FIFO full, with a read pop on the same cycle as push of 8'h5A -> count stays 8, and 8'h5A is read last.
REQ-033 SHALL cover: assert rst_n low during DATA bit 5, release, then send frame 8'h29 -> FIFO holds only 8'h29, overflow 0.
